// File: rtl/axi4_stream_fifo_reader_pkg.sv
// Shared helpers for the buffered AXI4-Stream reader: width calculations
// used by the FIFO and the top-level port declarations.
package axi4_stream_fifo_reader_pkg;

  // Ceiling log2. Used both for pointer width and for occupancy width.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

  // Number of byte strobes for a given stream data width.
  function automatic int unsigned strb_w(input int unsigned dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/streamif_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO. The head entry is always
// visible on rd_data; full/empty are registered and derived from the count.
module streamif_sync_fifo
  import axi4_stream_fifo_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              wr_data,
  output logic                          full,
  input  logic                          rd_en,
  output logic [WIDTH-1:0]              rd_data,
  output logic                          empty,
  output logic [clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam int unsigned CW = clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt_nxt;
  logic             push;
  logic             pop;

  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    cnt_nxt = count;
    case ({push, pop})
      2'b10:   cnt_nxt = count + CW'(1);
      2'b01:   cnt_nxt = count - CW'(1);
      default: cnt_nxt = count;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= cnt_nxt;
      full  <= (cnt_nxt == CW'(DEPTH));
      empty <= (cnt_nxt == '0);
    end
  end

  // Storage carries no reset; entries are only observed while counted.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/axi4_stream_fifo_reader.sv
// AXI4-Stream slave buffered through a FWFT FIFO; forwards TDATA/TSTRB/TLAST
// to the consumer and counts completed packets popped by the consumer.
module axi4_stream_fifo_reader
  import axi4_stream_fifo_reader_pkg::*;
#(
  parameter int unsigned C_S_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_FIFO_DEPTH         = 16,
  parameter int unsigned C_PKT_CNT_WIDTH      = 32
) (
  input  logic                                       S_AXIS_ACLK,
  input  logic                                       S_AXIS_ARESET,
  output logic                                       S_AXIS_TREADY,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]            S_AXIS_TDATA,
  input  logic [strb_w(C_S_AXIS_TDATA_WIDTH)-1:0]    S_AXIS_TSTRB,
  input  logic                                       S_AXIS_TLAST,
  input  logic                                       S_AXIS_TVALID,
  input  logic                                       ready,
  output logic                                       data_valid,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]            data,
  output logic [strb_w(C_S_AXIS_TDATA_WIDTH)-1:0]    data_strb,
  output logic                                       data_last,
  output logic [clog2(C_FIFO_DEPTH+1)-1:0]           fill_count,
  output logic [C_PKT_CNT_WIDTH-1:0]                 packet_count
);

  localparam int unsigned DW = C_S_AXIS_TDATA_WIDTH;
  localparam int unsigned SW = strb_w(C_S_AXIS_TDATA_WIDTH);
  localparam int unsigned EW = DW + SW + 1;

  logic          full;
  logic          empty;
  logic          pop;
  logic [EW-1:0] head;

  // Entry layout: {last, strb, data}.
  streamif_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .clk     (S_AXIS_ACLK),
    .rst     (S_AXIS_ARESET),
    .wr_en   (S_AXIS_TVALID),
    .wr_data ({S_AXIS_TLAST, S_AXIS_TSTRB, S_AXIS_TDATA}),
    .full    (full),
    .rd_en   (ready),
    .rd_data (head),
    .empty   (empty),
    .count   (fill_count)
  );

  assign S_AXIS_TREADY = ~full;
  assign data_valid    = ~empty;
  assign {data_last, data_strb, data} = head;
  assign pop           = ready & ~empty;

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      packet_count <= '0;
    end else if (pop && data_last) begin
      packet_count <= packet_count + C_PKT_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_axi4_stream_fifo_reader.sv
// Self-checking bench: a depth-16 and a depth-2 instance share stimulus; each
// is tracked by its own queue scoreboard, plus table vectors and corner cases.
module tb_axi4_stream_fifo_reader;

  logic        clk = 1'b0;
  logic        arst, tvalid, tlast, rdy;
  logic [31:0] tdata;
  logic [3:0]  tstrb;

  logic        trdy_a, dv_a, l_a, trdy_b, dv_b, l_b;
  logic [31:0] d_a, d_b, pc_a, pc_b;
  logic [3:0]  s_a, s_b;
  logic [4:0]  fc_a;
  logic [1:0]  fc_b;

  always #5 clk = ~clk;

  axi4_stream_fifo_reader #(
    .C_S_AXIS_TDATA_WIDTH(32), .C_FIFO_DEPTH(16), .C_PKT_CNT_WIDTH(32)
  ) dut_a (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(arst), .S_AXIS_TREADY(trdy_a),
    .S_AXIS_TDATA(tdata), .S_AXIS_TSTRB(tstrb), .S_AXIS_TLAST(tlast),
    .S_AXIS_TVALID(tvalid), .ready(rdy), .data_valid(dv_a), .data(d_a),
    .data_strb(s_a), .data_last(l_a), .fill_count(fc_a), .packet_count(pc_a)
  );

  axi4_stream_fifo_reader #(
    .C_S_AXIS_TDATA_WIDTH(32), .C_FIFO_DEPTH(2), .C_PKT_CNT_WIDTH(32)
  ) dut_b (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(arst), .S_AXIS_TREADY(trdy_b),
    .S_AXIS_TDATA(tdata), .S_AXIS_TSTRB(tstrb), .S_AXIS_TLAST(tlast),
    .S_AXIS_TVALID(tvalid), .ready(rdy), .data_valid(dv_b), .data(d_b),
    .data_strb(s_b), .data_last(l_b), .fill_count(fc_b), .packet_count(pc_b)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
  } ent_t;

  typedef struct {
    logic        rst;
    logic        tv;
    logic [31:0] td;
    logic [3:0]  ts;
    logic        tl;
    logic        rd;
    logic        e_trdy;
    logic        e_dv;
    logic [31:0] e_d;
    int          e_fc;
    int          e_pc;
  } vec_t;

  vec_t vecs[9];
  ent_t qa[$];
  ent_t qb[$];
  int   pca = 0, pcb = 0, na = 0, seq = 0;
  int   checks = 0, failures = 0;
  bit   sb_en = 1'b0;
  int   base;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare one instance against its model, then advance the model by one edge.
  task automatic sb(input int id, input int depth, input logic trdy, input logic dv,
                    input logic [31:0] d, input logic [3:0] s, input logic l,
                    input logic [63:0] fc, input logic [63:0] pc);
    ent_t  h;
    int    sz;
    string p;
    p  = (id == 0) ? "a" : "b";
    sz = (id == 0) ? qa.size() : qb.size();
    h  = '0;
    if (sz > 0) h = (id == 0) ? qa[0] : qb[0];
    if (sb_en) begin
      chk({p, "_tready"}, 64'(trdy), 64'(sz != depth));
      chk({p, "_data_valid"}, 64'(dv), 64'(sz != 0));
      chk({p, "_fill_count"}, fc, 64'(sz));
      chk({p, "_packet_count"}, pc, 64'((id == 0) ? pca : pcb));
      if (sz > 0) begin
        chk({p, "_data"}, 64'(d), 64'(h.d));
        chk({p, "_strb"}, 64'(s), 64'(h.s));
        chk({p, "_last"}, 64'(l), 64'(h.l));
      end
    end
    if (arst) begin
      if (id == 0) begin qa.delete(); pca = 0; end
      else begin qb.delete(); pcb = 0; end
    end else begin
      if (rdy && sz != 0) begin
        if (id == 0) begin h = qa.pop_front(); if (h.l) pca++; end
        else begin h = qb.pop_front(); if (h.l) pcb++; end
      end
      if (tvalid && sz != depth) begin
        if (id == 0) begin qa.push_back({tdata, tstrb, tlast}); na++; end
        else qb.push_back({tdata, tstrb, tlast});
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sb(0, 16, trdy_a, dv_a, d_a, s_a, l_a, 64'(fc_a), 64'(pc_a));
    sb(1, 2, trdy_b, dv_b, d_b, s_b, l_b, 64'(fc_b), 64'(pc_b));
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic last, input logic r);
    seq++;
    tvalid = v;
    tlast  = last;
    rdy    = r;
    tdata  = 32'h5A00_0000 | 32'(seq);
    tstrb  = 4'(seq ^ (seq >> 4));
  endtask

  task automatic drain(input string nm);
    tvalid = 1'b0;
    rdy    = 1'b1;
    for (int i = 0; i < 64 && (qa.size() != 0 || qb.size() != 0); i++) tick();
    chk({nm, "_a_empty"}, 64'(fc_a), 64'd0);
    chk({nm, "_b_empty"}, 64'(fc_b), 64'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        0, 0};
    vecs[1] = '{1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        0, 0};
    vecs[2] = '{1'b0, 1'b1, 32'h11111111, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11111111, 1, 0};
    vecs[3] = '{1'b0, 1'b1, 32'h22222222, 4'h3, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11111111, 2, 0};
    vecs[4] = '{1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h22222222, 1, 0};
    vecs[5] = '{1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        0, 1};
    vecs[6] = '{1'b0, 1'b1, 32'h33333333, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1, 32'h33333333, 1, 1};
    vecs[7] = '{1'b0, 1'b1, 32'h44444444, 4'h1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44444444, 1, 2};
    vecs[8] = '{1'b0, 1'b0, 32'h0,        4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        0, 2};

    arst = 1'b1; tvalid = 1'b0; tlast = 1'b0; rdy = 1'b0; tdata = '0; tstrb = '0;
    tick();
    sb_en = 1'b1;

    // Table vectors: reset, first-word latency, pops, simultaneous push/pop.
    for (int i = 0; i < 9; i++) begin
      arst = vecs[i].rst; tvalid = vecs[i].tv; tdata = vecs[i].td;
      tstrb = vecs[i].ts; tlast = vecs[i].tl; rdy = vecs[i].rd;
      tick();
      chk($sformatf("vec%0d_tready", i), 64'(trdy_a), 64'(vecs[i].e_trdy));
      chk($sformatf("vec%0d_valid", i), 64'(dv_a), 64'(vecs[i].e_dv));
      chk($sformatf("vec%0d_fill", i), 64'(fc_a), 64'(vecs[i].e_fc));
      chk($sformatf("vec%0d_pcnt", i), 64'(pc_a), 64'(vecs[i].e_pc));
      if (vecs[i].e_dv) chk($sformatf("vec%0d_data", i), 64'(d_a), 64'(vecs[i].e_d));
    end
    arst = 1'b0;

    // Fill to full with the consumer stalled, then free exactly one entry.
    for (int i = 0; i < 20; i++) begin drive(1'b1, 1'b0, 1'b0); tick(); end
    chk("full_fill", 64'(fc_a), 64'd16);
    chk("full_tready", 64'(trdy_a), 64'd0);
    drive(1'b1, 1'b0, 1'b1); tick();
    chk("full_pop_tready", 64'(trdy_a), 64'd1);
    chk("full_pop_fill", 64'(fc_a), 64'd15);
    drive(1'b1, 1'b0, 1'b0); tick();
    chk("refill_fill", 64'(fc_a), 64'd16);
    chk("refill_tready", 64'(trdy_a), 64'd0);
    drain("full_drain");

    // Streaming 4-word packets at full rate.
    base = pca;
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, (i % 4) == 3, 1'b1); tick();
      chk("stream_fill_le1", 64'(fc_a <= 5'd1), 64'd1);
      chk("stream_no_bubble", 64'(dv_a), 64'd1);
    end
    drain("stream_drain");
    chk("stream_pkts", 64'(pc_a), 64'(base + 16));

    // Random handshakes on both depths.
    na = 0;
    for (int c = 0; c < 20000 && na < 1000; c++) begin
      tvalid = 1'($urandom_range(0, 1));
      rdy    = 1'($urandom_range(0, 1));
      tlast  = ($urandom_range(0, 3) == 0);
      tdata  = $urandom;
      tstrb  = 4'($urandom);
      tick();
    end
    chk("rand_words", 64'(na >= 1000), 64'd1);
    drain("rand_drain");

    // Reset in the middle of a buffered packet, then a fresh packet.
    for (int i = 0; i < 7; i++) begin drive(1'b1, i == 2, 1'b0); tick(); end
    chk("mid_fill", 64'(fc_a), 64'd7);
    arst = 1'b1; drive(1'b1, 1'b0, 1'b0); tick();
    arst = 1'b0; tvalid = 1'b0;
    chk("rst_fill", 64'(fc_a), 64'd0);
    chk("rst_valid", 64'(dv_a), 64'd0);
    chk("rst_pcnt", 64'(pc_a), 64'd0);
    chk("rst_tready", 64'(trdy_a), 64'd1);
    for (int i = 0; i < 3; i++) begin drive(1'b1, i == 2, 1'b1); tick(); end
    drain("post_rst_drain");
    chk("post_rst_pcnt", 64'(pc_a), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
